// File: rtl/scarv_cop_palu_seq.sv
// Packed-ALU issue sequencer: decode handshake in, PALU issue,
// result capture and CPR writeback handshake out, with watchdog.
module scarv_cop_palu_seq #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        i_g_clk,
  input  logic        i_g_reset,
  input  logic        i_flush,
  input  logic        i_dec_valid,
  output logic        o_dec_ready,
  input  logic [31:0] i_dec_gpr_rs1,
  input  logic [31:0] i_dec_rs1,
  input  logic [31:0] i_dec_rs2,
  input  logic [31:0] i_dec_rs3,
  input  logic [31:0] i_dec_imm,
  input  logic [2:0]  i_dec_pw,
  input  logic [8:0]  i_dec_class,
  input  logic [15:0] i_dec_subclass,
  input  logic [3:0]  i_dec_rd,
  output logic        o_palu_ivalid,
  input  logic        i_palu_idone,
  output logic [31:0] o_palu_gpr_rs1,
  output logic [31:0] o_palu_rs1,
  output logic [31:0] o_palu_rs2,
  output logic [31:0] o_palu_rs3,
  output logic [31:0] o_palu_imm,
  output logic [2:0]  o_palu_pw,
  output logic [8:0]  o_palu_class,
  output logic [15:0] o_palu_subclass,
  input  logic [3:0]  i_palu_ben,
  input  logic [31:0] i_palu_wdata,
  output logic        o_wb_valid,
  input  logic        i_wb_ready,
  output logic [3:0]  o_wb_rd,
  output logic [3:0]  o_wb_ben,
  output logic [31:0] o_wb_wdata,
  output logic        o_err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ivalid;
  logic             r_wbv;
  logic             r_err;
  logic [31:0]      r_gpr;
  logic [31:0]      r_rs1;
  logic [31:0]      r_rs2;
  logic [31:0]      r_rs3;
  logic [31:0]      r_imm;
  logic [2:0]       r_pw;
  logic [8:0]       r_cls;
  logic [15:0]      r_sub;
  logic [3:0]       r_rd;
  logic [3:0]       r_wb_rd;
  logic [3:0]       r_wb_ben;
  logic [31:0]      r_wb_wdata;

  logic w_dec_ready;
  logic w_accept;
  logic w_done;
  logic w_tmo;
  logic w_wb_cap;
  logic w_wb_take;

  assign w_dec_ready = !i_g_reset && !i_flush &&
                       ((r_state == S_IDLE) ||
                        ((r_state == S_WB) && i_wb_ready));
  assign w_accept  = i_dec_valid && w_dec_ready;
  assign w_done    = (r_state == S_EXEC) && i_palu_idone;
  assign w_tmo     = (r_state == S_EXEC) && !i_palu_idone &&
                     (r_cnt == LAST);
  assign w_wb_cap  = w_done && (i_palu_ben != 4'd0);
  assign w_wb_take = (r_state == S_WB) && i_wb_ready;

  // Control FSM: state, EXEC cycle counter and registered flags
  always_ff @(posedge i_g_clk) begin
    if (i_g_reset || i_flush) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ivalid <= 1'b0;
      r_wbv    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_tmo;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state  <= S_EXEC;
            r_cnt    <= '0;
            r_ivalid <= 1'b1;
          end
        end
        S_EXEC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_done) begin
            r_ivalid <= 1'b0;
            if (w_wb_cap) begin
              r_state <= S_WB;
              r_wbv   <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_tmo) begin
            r_ivalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_WB: begin
          if (i_wb_ready) begin
            r_wbv <= 1'b0;
            if (w_accept) begin
              r_state  <= S_EXEC;
              r_cnt    <= '0;
              r_ivalid <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand registers: loaded on accept, wiped once EXEC ends
  always_ff @(posedge i_g_clk) begin
    if (i_g_reset || i_flush || w_done || w_tmo) begin
      r_gpr <= '0;
      r_rs1 <= '0;
      r_rs2 <= '0;
      r_rs3 <= '0;
      r_imm <= '0;
      r_pw  <= '0;
      r_cls <= '0;
      r_sub <= '0;
    end else if (w_accept) begin
      r_gpr <= i_dec_gpr_rs1;
      r_rs1 <= i_dec_rs1;
      r_rs2 <= i_dec_rs2;
      r_rs3 <= i_dec_rs3;
      r_imm <= i_dec_imm;
      r_pw  <= i_dec_pw;
      r_cls <= i_dec_class;
      r_sub <= i_dec_subclass;
    end
  end

  // Destination index travels with the op until writeback capture
  always_ff @(posedge i_g_clk) begin
    if (i_g_reset || i_flush) begin
      r_rd <= '0;
    end else if (w_accept) begin
      r_rd <= i_dec_rd;
    end
  end

  // Writeback holding registers, cleared once consumed
  always_ff @(posedge i_g_clk) begin
    if (i_g_reset || i_flush || w_wb_take) begin
      r_wb_rd    <= '0;
      r_wb_ben   <= '0;
      r_wb_wdata <= '0;
    end else if (w_wb_cap) begin
      r_wb_rd    <= r_rd;
      r_wb_ben   <= i_palu_ben;
      r_wb_wdata <= i_palu_wdata;
    end
  end

  assign o_dec_ready     = w_dec_ready;
  assign o_palu_ivalid   = r_ivalid;
  assign o_palu_gpr_rs1  = r_gpr;
  assign o_palu_rs1      = r_rs1;
  assign o_palu_rs2      = r_rs2;
  assign o_palu_rs3      = r_rs3;
  assign o_palu_imm      = r_imm;
  assign o_palu_pw       = r_pw;
  assign o_palu_class    = r_cls;
  assign o_palu_subclass = r_sub;
  assign o_wb_valid      = r_wbv;
  assign o_wb_rd         = r_wb_rd;
  assign o_wb_ben        = r_wb_ben;
  assign o_wb_wdata      = r_wb_wdata;
  assign o_err_timeout   = r_err;

endmodule
